// File: rtl/fp_pkg.sv
// Shared IEEE-754 format constants and classification helpers for the fp arith units.
// Helpers take the format as run-time ints so any width up to 64 bits can use them.
package fp_pkg;

  localparam int HALF_EXP_W    = 5;
  localparam int HALF_FRAC_W   = 10;
  localparam int SINGLE_EXP_W  = 8;
  localparam int SINGLE_FRAC_W = 23;
  localparam int DOUBLE_EXP_W  = 11;
  localparam int DOUBLE_FRAC_W = 52;
  localparam int MAX_W         = 64;

  typedef logic [MAX_W-1:0] fp_word_t;

  // Sign 0, exponent all ones, quiet bit set, rest of fraction clear.
  function automatic fp_word_t canon_qnan(input int bitwidth, input int exp_w);
    fp_word_t r;
    int frac_w;
    frac_w = bitwidth - 1 - exp_w;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= frac_w - 1 && i < bitwidth - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic is_nan(input fp_word_t x, input int bitwidth, input int exp_w);
    logic exp_ones;
    logic frac_nz;
    int frac_w;
    frac_w   = bitwidth - 1 - exp_w;
    exp_ones = 1'b1;
    frac_nz  = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < frac_w) frac_nz = frac_nz | x[i];
      else if (i < bitwidth - 1) exp_ones = exp_ones & x[i];
    end
    return exp_ones & frac_nz;
  endfunction

  function automatic logic is_zero(input fp_word_t x, input int bitwidth);
    logic nz;
    nz = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < bitwidth - 1) nz = nz | x[i];
    end
    return !nz;
  endfunction

endpackage

// File: rtl/fp_minmax_core.sv
// Combinational IEEE-754 min/max select with configurable NaN policy; zero latency.
// No handshake of its own; the wrapper owns flow control.
module fp_minmax_core
  import fp_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int EXP_W    = 8,
  parameter int IS_MIN   = 0,
  parameter int NAN_PROP = 1
) (
  input  logic [BITWIDTH-1:0] lhs,
  input  logic [BITWIDTH-1:0] rhs,
  output logic [BITWIDTH-1:0] result
);

  localparam fp_word_t QNAN = canon_qnan(BITWIDTH, EXP_W);

  logic                lhs_nan;
  logic                rhs_nan;
  logic [BITWIDTH-1:0] lhs_key;
  logic [BITWIDTH-1:0] rhs_key;
  logic                rhs_wins;

  // Mapping sign-magnitude onto an unsigned key makes the total order a plain
  // compare: negatives invert (reversed magnitude), positives get the top bit set.
  always_comb begin
    lhs_nan  = is_nan(MAX_W'(lhs), BITWIDTH, EXP_W);
    rhs_nan  = is_nan(MAX_W'(rhs), BITWIDTH, EXP_W);
    lhs_key  = lhs[BITWIDTH-1] ? ~lhs : {1'b1, lhs[BITWIDTH-2:0]};
    rhs_key  = rhs[BITWIDTH-1] ? ~rhs : {1'b1, rhs[BITWIDTH-2:0]};
    rhs_wins = (IS_MIN != 0) ? (rhs_key < lhs_key) : (rhs_key > lhs_key);
    if (lhs_nan || rhs_nan) begin
      if (NAN_PROP != 0 || (lhs_nan && rhs_nan)) result = QNAN[BITWIDTH-1:0];
      else result = lhs_nan ? rhs : lhs;
    end else begin
      result = rhs_wins ? rhs : lhs;
    end
  end

endmodule

// File: rtl/fp_minmax_pipe.sv
// Elastic fp min/max: joins lhs/rhs, LATENCY register stages (0 = combinational).
// Per-stage valid/ready; empty stages keep loading under an output stall.
module fp_minmax_pipe
  import fp_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int EXP_W    = 8,
  parameter int LATENCY  = 2,
  parameter int IS_MIN   = 0,
  parameter int NAN_PROP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITWIDTH-1:0] lhs,
  input  logic                lhs_valid,
  output logic                lhs_ready,
  input  logic [BITWIDTH-1:0] rhs,
  input  logic                rhs_valid,
  output logic                rhs_ready,
  output logic [BITWIDTH-1:0] result,
  output logic                result_valid,
  input  logic                result_ready
);

  logic [BITWIDTH-1:0] f_res;
  logic                join_valid;
  logic                s0_ready;

  fp_minmax_core #(
    .BITWIDTH(BITWIDTH),
    .EXP_W   (EXP_W),
    .IS_MIN  (IS_MIN),
    .NAN_PROP(NAN_PROP)
  ) u_core (
    .lhs   (lhs),
    .rhs   (rhs),
    .result(f_res)
  );

  assign join_valid = lhs_valid & rhs_valid;
  assign lhs_ready  = rhs_valid & s0_ready;
  assign rhs_ready  = lhs_valid & s0_ready;

  if (LATENCY == 0) begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign result         = f_res;
    assign result_valid   = join_valid;
    assign s0_ready       = result_ready;
  end else begin : g_pipe
    logic [LATENCY-1:0]               v;
    logic [LATENCY-1:0]               up_v;
    logic [LATENCY-1:0]               rdy;
    logic [LATENCY-1:0][BITWIDTH-1:0] d;
    logic [LATENCY-1:0][BITWIDTH-1:0] up_d;
    logic                             rdy_chain;

    // A stage is ready when empty or when everything downstream can move.
    always_comb begin
      up_v[0] = join_valid;
      up_d[0] = f_res;
      for (int i = 1; i < LATENCY; i++) begin
        up_v[i] = v[i-1];
        up_d[i] = d[i-1];
      end
      rdy_chain        = ~v[LATENCY-1] | result_ready;
      rdy[LATENCY-1]   = rdy_chain;
      for (int i = LATENCY - 2; i >= 0; i--) begin
        rdy_chain = ~v[i] | rdy_chain;
        rdy[i]    = rdy_chain;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        v <= '0;
        d <= '0;
      end else begin
        for (int i = 0; i < LATENCY; i++) begin
          if (rdy[i]) begin
            v[i] <= up_v[i];
            if (up_v[i]) d[i] <= up_d[i];
          end
        end
      end
    end

    // In reset the pipeline is about to be empty, so advertise room already.
    assign s0_ready     = rdy[0] | ~rst;
    assign result       = d[LATENCY-1];
    assign result_valid = v[LATENCY-1];
  end

endmodule

// File: tb/tb_fp_minmax_pipe.sv
// Scoreboard bench: five fp_minmax_pipe configurations share one stimulus stream.
module tb_fp_minmax_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] lhs = '0;
  logic [63:0] rhs = '0;
  logic        lhs_valid = 1'b0;
  logic        rhs_valid = 1'b0;
  logic        result_ready = 1'b0;

  always #5 clk = ~clk;

  // 0: max lat2, 1: min lat2, 2: max NaN-num lat2, 3: max lat0, 4: double max lat2
  logic        lr [5];
  logic        rr [5];
  logic        rv [5];
  logic [63:0] res [5];
  logic [31:0] res32 [4];
  logic [63:0] res64;

  int dbw  [5] = '{32, 32, 32, 32, 64};
  int dew  [5] = '{8, 8, 8, 8, 11};
  int dmin [5] = '{0, 1, 0, 0, 0};
  int dnp  [5] = '{1, 1, 0, 1, 1};

  fp_minmax_pipe #(.BITWIDTH(32), .EXP_W(8), .LATENCY(2), .IS_MIN(0), .NAN_PROP(1)) u_a (
    .clk(clk), .rst(rst), .lhs(lhs[31:0]), .lhs_valid(lhs_valid), .lhs_ready(lr[0]),
    .rhs(rhs[31:0]), .rhs_valid(rhs_valid), .rhs_ready(rr[0]),
    .result(res32[0]), .result_valid(rv[0]), .result_ready(result_ready));
  fp_minmax_pipe #(.BITWIDTH(32), .EXP_W(8), .LATENCY(2), .IS_MIN(1), .NAN_PROP(1)) u_b (
    .clk(clk), .rst(rst), .lhs(lhs[31:0]), .lhs_valid(lhs_valid), .lhs_ready(lr[1]),
    .rhs(rhs[31:0]), .rhs_valid(rhs_valid), .rhs_ready(rr[1]),
    .result(res32[1]), .result_valid(rv[1]), .result_ready(result_ready));
  fp_minmax_pipe #(.BITWIDTH(32), .EXP_W(8), .LATENCY(2), .IS_MIN(0), .NAN_PROP(0)) u_c (
    .clk(clk), .rst(rst), .lhs(lhs[31:0]), .lhs_valid(lhs_valid), .lhs_ready(lr[2]),
    .rhs(rhs[31:0]), .rhs_valid(rhs_valid), .rhs_ready(rr[2]),
    .result(res32[2]), .result_valid(rv[2]), .result_ready(result_ready));
  fp_minmax_pipe #(.BITWIDTH(32), .EXP_W(8), .LATENCY(0), .IS_MIN(0), .NAN_PROP(1)) u_d (
    .clk(clk), .rst(rst), .lhs(lhs[31:0]), .lhs_valid(lhs_valid), .lhs_ready(lr[3]),
    .rhs(rhs[31:0]), .rhs_valid(rhs_valid), .rhs_ready(rr[3]),
    .result(res32[3]), .result_valid(rv[3]), .result_ready(result_ready));
  fp_minmax_pipe #(.BITWIDTH(64), .EXP_W(11), .LATENCY(2), .IS_MIN(0), .NAN_PROP(1)) u_e (
    .clk(clk), .rst(rst), .lhs(lhs), .lhs_valid(lhs_valid), .lhs_ready(lr[4]),
    .rhs(rhs), .rhs_valid(rhs_valid), .rhs_ready(rr[4]),
    .result(res64), .result_valid(rv[4]), .result_ready(result_ready));

  assign res[0] = 64'(res32[0]);
  assign res[1] = 64'(res32[1]);
  assign res[2] = 64'(res32[2]);
  assign res[3] = 64'(res32[3]);
  assign res[4] = res64;

  int total = 0;
  int bad   = 0;
  int acc [5] = '{0, 0, 0, 0, 0};
  logic [63:0] sbq [5][$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: compare sign first, then magnitude (reversed for negatives).
  function automatic logic [63:0] model(input logic [63:0] a_in, input logic [63:0] b_in,
                                        input int bw, input int ew, input int mn, input int np);
    logic [63:0] wmask, mmask, emask, fmask, qn, a, b, ma, mb;
    logic an, bn, sa, sb, lt, gt;
    int fw;
    fw    = bw - 1 - ew;
    wmask = (bw == 64) ? '1 : ((64'd1 << bw) - 64'd1);
    a     = a_in & wmask;
    b     = b_in & wmask;
    mmask = (64'd1 << (bw - 1)) - 64'd1;
    emask = (64'd1 << ew) - 64'd1;
    fmask = (64'd1 << fw) - 64'd1;
    qn    = (emask << fw) | (64'd1 << (fw - 1));
    an    = (((a >> fw) & emask) == emask) && ((a & fmask) != 0);
    bn    = (((b >> fw) & emask) == emask) && ((b & fmask) != 0);
    if (an || bn) begin
      if (np != 0 || (an && bn)) return qn;
      return an ? b : a;
    end
    sa = a[bw-1];
    sb = b[bw-1];
    ma = a & mmask;
    mb = b & mmask;
    if (sa != sb) begin
      lt = sa;
      gt = sb;
    end else if (!sa) begin
      lt = ma < mb;
      gt = ma > mb;
    end else begin
      lt = ma > mb;
      gt = ma < mb;
    end
    if (mn != 0) return gt ? b : a;
    return lt ? b : a;
  endfunction

  // Handshakes are sampled mid-cycle; they complete on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 5; k++) sbq[k].delete();
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (lhs_valid && rhs_valid && lr[k]) begin
          sbq[k].push_back(model(lhs, rhs, dbw[k], dew[k], dmin[k], dnp[k]));
          acc[k]++;
        end
        if (rv[k] && result_ready) begin
          if (sbq[k].size() == 0) chk($sformatf("sb_spurious%0d", k), 64'(rv[k]), 64'd0);
          else chk($sformatf("sb_data%0d", k), res[k], sbq[k].pop_front());
        end
      end
    end
  end

  // Present one token and hold it until the first instance takes it.
  task automatic send(input logic [63:0] l, input logic [63:0] r);
    int n;
    lhs = l;
    rhs = r;
    lhs_valid = 1'b1;
    rhs_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!lr[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    lhs_valid = 1'b0;
    rhs_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() + sbq[4].size()) != 0
           && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    for (int k = 0; k < 5; k++) chk($sformatf("drain_empty%0d", k), 64'(sbq[k].size()), 64'd0);
  endtask

  logic [31:0] t_l [9] = '{32'h3F800000, 32'h80000000, 32'h00000000, 32'h7FA00000, 32'h7FA00000,
                           32'h3F800000, 32'hFF800000, 32'h00000002, 32'hC0000000};
  logic [31:0] t_r [9] = '{32'h40000000, 32'h00000000, 32'h80000000, 32'h3F800000, 32'hFFC00001,
                           32'h7F800001, 32'h00000001, 32'h00000001, 32'hBF800000};
  logic [31:0] t_mx [9] = '{32'h40000000, 32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000,
                            32'h7FC00000, 32'h00000001, 32'h00000002, 32'hBF800000};
  logic [31:0] t_mn [9] = '{32'h3F800000, 32'h80000000, 32'h80000000, 32'h7FC00000, 32'h7FC00000,
                            32'h7FC00000, 32'hFF800000, 32'h00000001, 32'hC0000000};
  logic [31:0] t_nn [9] = '{32'h40000000, 32'h00000000, 32'h00000000, 32'h3F800000, 32'h7FC00000,
                            32'h3F800000, 32'h00000001, 32'h00000002, 32'hBF800000};
  logic [63:0] w_l [3] = '{64'hC000000000000000, 64'h7FF4000000000000, 64'h8000000000000000};
  logic [63:0] w_r [3] = '{64'h3FF0000000000000, 64'h0000000000000000, 64'h0000000000000000};
  logic [63:0] w_x [3] = '{64'h3FF0000000000000, 64'h7FF8000000000000, 64'h0000000000000000};

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int a0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(rv[0]), 64'd0);
    chk("rst_result", res[0], 64'd0);
    chk("rst_valid_dbl", 64'(rv[4]), 64'd0);
    rst = 1'b1;
    result_ready = 1'b1;
    @(posedge clk);
    #1;

    // Directed single-precision vectors with latency check.
    for (int i = 0; i < 9; i++) begin
      lhs = 64'(t_l[i]);
      rhs = 64'(t_r[i]);
      lhs_valid = 1'b1;
      rhs_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("lat0_comb%0d", i), res[3], 64'(t_mx[i]));
      chk($sformatf("accept%0d", i), 64'(lr[0]), 64'd1);
      @(posedge clk);
      #1;
      lhs_valid = 1'b0;
      rhs_valid = 1'b0;
      chk($sformatf("lat_c1_%0d", i), 64'(rv[0]), 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("lat_c2_%0d", i), 64'(rv[0]), 64'd1);
      chk($sformatf("max%0d", i), res[0], 64'(t_mx[i]));
      chk($sformatf("min%0d", i), res[1], 64'(t_mn[i]));
      chk($sformatf("nanum%0d", i), res[2], 64'(t_nn[i]));
    end

    // Directed double-precision vectors.
    for (int i = 0; i < 3; i++) begin
      send(w_l[i], w_r[i]);
      @(posedge clk);
      #1;
      chk($sformatf("dbl_valid%0d", i), 64'(rv[4]), 64'd1);
      chk($sformatf("dbl_max%0d", i), res[4], w_x[i]);
    end
    drain();

    // Backpressure: 6 tokens, output stalled for 5 cycles.
    result_ready = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_lhs_ready_low", 64'(lr[0]), 64'd0);
        chk("bp_out_valid", 64'(rv[0]), 64'd1);
        @(posedge clk);
        #1;
        result_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 6; k++) send({$urandom, $urandom}, {$urandom, $urandom});
      end
    join
    drain();

    // Bubble collapse: a stalled output must not block an empty middle stage.
    result_ready = 1'b0;
    a0 = acc[0];
    send(64'h3F800000, 64'hBF800000);
    @(posedge clk);
    #1;
    chk("bubble_adv", 64'(rv[0]), 64'd1);
    send(64'h40400000, 64'h40800000);
    chk("bubble_acc", 64'(acc[0] - a0), 64'd2);
    @(negedge clk);
    chk("bubble_full_valid", 64'(rv[0]), 64'd1);
    result_ready = 1'b1;
    drain();

    // Unequal arrival: no consumption until both operands are valid.
    a0 = acc[0];
    lhs = 64'h41200000;
    rhs = 64'hC1200000;
    lhs_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("uneq_lr%0d", c), 64'(lr[0]), 64'd0);
      @(posedge clk);
      #1;
    end
    chk("uneq_none", 64'(acc[0] - a0), 64'd0);
    rhs_valid = 1'b1;
    @(negedge clk);
    chk("uneq_lr_go", 64'(lr[0]), 64'd1);
    @(posedge clk);
    #1;
    lhs_valid = 1'b0;
    rhs_valid = 1'b0;
    chk("uneq_one", 64'(acc[0] - a0), 64'd1);
    drain();

    // Reset with two tokens in flight.
    result_ready = 1'b0;
    send(64'h3F800000, 64'h40000000);
    send(64'h40400000, 64'h40800000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("mrst_valid", 64'(rv[0]), 64'd0);
    chk("mrst_result", res[0], 64'd0);
    chk("mrst_valid_dbl", 64'(rv[4]), 64'd0);
    result_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mrst_no_stale", 64'(rv[0]), 64'd0);
    end
    @(posedge clk);
    #1;
    lhs = 64'h3F800000;
    rhs = 64'h40000000;
    lhs_valid = 1'b1;
    rhs_valid = 1'b1;
    @(posedge clk);
    #1;
    lhs_valid = 1'b0;
    rhs_valid = 1'b0;
    chk("post_rst_c1", 64'(rv[0]), 64'd0);
    @(posedge clk);
    #1;
    chk("post_rst_c2", 64'(rv[0]), 64'd1);
    chk("post_rst_data", res[0], 64'h40000000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_minmax_pipe.md
Name: fp_minmax_pipe

Overview:
- Elastic, parametrised IEEE-754 min/max operator for dataflow circuits; the next generation of the single-precision maxf wrapper.
- Generalised over width and format: half, single and double precision.
- Selectable min or max mode, configurable pipeline depth, and a configurable NaN policy.
- Full per-stage backpressure: a stalled output does not block stages that are empty (bubbles are collapsed).
- Sits between handshake channels like any other arith unit; the operands are joined, then pass through a valid/ready pipeline.

Parameters:
- BITWIDTH, 32, total operand width (16, 32 or 64).
- EXP_W, 8, exponent field width (5, 8 or 11). FRAC_W = BITWIDTH-1-EXP_W.
- LATENCY, 2, number of register stages (0..4). 0 means a purely combinational path.
- IS_MIN, 0, 0 selects maximum and 1 selects minimum.
- NAN_PROP, 1, 1 means any NaN input yields canonical qNaN; 0 means maxNum/minNum semantics.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets).
- lhs  in  BITWIDTH  left operand.
- lhs_valid  in  1  left operand valid.
- lhs_ready  out  1  left operand accepted.
- rhs  in  BITWIDTH  right operand.
- rhs_valid  in  1  right operand valid.
- rhs_ready  out  1  right operand accepted.
- result  out  BITWIDTH  min/max result.
- result_valid  out  1  result valid.
- result_ready  in  1  downstream ready.

Behaviour:
Join
- join_valid = lhs_valid & rhs_valid.
- lhs_ready = rhs_valid & s0_ready; rhs_ready = lhs_valid & s0_ready.
- An operand is consumed only on the cycle both are valid and stage 0 accepts. A lone operand waits; there is no partial capture.

Pipeline (LATENCY=N>0)
- Stages 0..N-1, each holding v[i] and d[i].
- ready[N-1] = !v[N-1] | result_ready; ready[i] = !v[i] | ready[i+1]. s0_ready = ready[0].
- Stage 0 loads the computed result when join_valid & ready[0]. Stage i loads from stage i-1 when ready[i].
- v[i] is cleared when ready[i] holds and the upstream stage is not valid.
- Data registers load only when the load condition holds; otherwise they hold.
- result = d[N-1]; result_valid = v[N-1].
- Latency is exactly N cycles with no stall. Throughput is 1 per cycle.

LATENCY=0
- result = f(lhs,rhs); result_valid = join_valid; s0_ready = result_ready.

Reset
- While rst=0 at a clock edge, all v[i] are cleared, so result_valid=0.
- Data registers are cleared to 0, so result=0 when LATENCY>0.
- Reset mid-operation discards all in-flight tokens. The first post-reset token sees the full latency N.
- While in reset (LATENCY>0), lhs_ready and rhs_ready reflect an empty pipeline, so a token can be accepted on the first edge with rst=1.

Arithmetic f
- Total order by sign-magnitude: negative values are ordered by reversed magnitude, and -0 < +0.
- Max returns the larger value; with IS_MIN=1 it returns the smaller.
- Equal encodings return lhs.
- NaN means exp all-ones and frac≠0. Canonical qNaN = sign 0, exp all-ones, frac MSB 1, remaining frac bits 0.
- NAN_PROP=1: any NaN operand produces canonical qNaN.
- NAN_PROP=0: exactly one NaN returns the other operand; two NaNs return canonical qNaN.
- Infinities order normally. Subnormals are compared exactly, with no flushing.

Simultaneous events
- A stage may unload and load in the same cycle (full throughput under result_ready=1).
- No token may be lost or duplicated under any valid/ready pattern.

Decomposition:
- Shared package fp_pkg: format constants (HALF/SINGLE/DOUBLE exp and frac widths), a canonical-qNaN constant function, and is_nan/is_zero helper functions.
- One sub-module: fp_minmax_core, a combinational compare/select parametrised by BITWIDTH, EXP_W, IS_MIN and NAN_PROP. The top level owns the join and the elastic stage chain, built with a generate loop over LATENCY.

Test Plan:
- Default params: lhs=0x3F800000 (1.0), rhs=0x40000000 (2.0), result_ready=1. Required: result=0x40000000 with result_valid exactly 2 cycles after acceptance. With IS_MIN=1 the result is 0x3F800000.
- Signed zero: lhs=0x80000000, rhs=0x00000000. Max gives 0x00000000 and min gives 0x80000000. With swapped operands the results are identical.
- NaN: lhs=0x7FA00000 (sNaN), rhs=0x3F800000. NAN_PROP=1 gives 0x7FC00000. NAN_PROP=0 gives 0x3F800000. Two NaNs give 0x7FC00000 in both modes.
- Backpressure:
  - Stream 6 tokens back-to-back with result_ready=0 for 5 cycles. lhs_ready must drop after 2 tokens are stored. On release, the 6 results must emerge in order with no loss or duplication.
  - Bubble collapse: v[0]=1 and v[1]=0 while stalled must still advance.
- Unequal arrival: lhs_valid at cycle 0 and rhs_valid at cycle 3. Neither ready is asserted before cycle 3, and exactly one token is consumed at cycle 3.
- Reset mid-flight: drive rst=0 for one cycle with 2 tokens in flight. Required: result_valid=0 the following cycle and no stale outputs. A fresh token issued afterwards appears after 2 cycles.
- Repeat the functional cases for BITWIDTH=64/EXP_W=11 (e.g. 0xC000000000000000 vs 0x3FF0000000000000, where max = 0x3FF0000000000000) and for LATENCY=0.
